// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard unit: scoreboard entry, forwarding select codes, defaults.
package pipe_pkg;

    // Widest register specifier the scoreboard can hold; REG_BITS must not exceed it.
    localparam int SB_DEST_W      = 8;
    localparam int DEPTH_DEF      = 3;
    localparam int LOAD_STAGE_DEF = 2;

    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 is_load;
    } sb_entry_t;

    // Select code for a result living k stages behind decode.
    function automatic int stage_sel(input int k);
        case (k)
            0:       return FWD_RF;
            1:       return FWD_EX;
            2:       return FWD_MEM;
            3:       return FWD_WB;
            default: return k;
        endcase
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side bundle of the hazard unit: decoded-instruction info in, stall/flush/forward controls out.
interface hazard_unit_if
    import pipe_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int SEL_W    = $clog2(DEPTH_DEF + 1)
);
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_uses_rs;
    logic                id_uses_rt;
    logic                id_regwrite;
    logic                id_memread;
    logic [REG_BITS-1:0] id_dest;
    logic                branch_taken;

    logic                stall;
    logic                pc_write;
    logic                ifid_write;
    logic                flush_ifid;
    logic [SEL_W-1:0]    fwd_a_sel;
    logic [SEL_W-1:0]    fwd_b_sel;
    logic [31:0]         stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_regwrite, id_memread, id_dest, branch_taken,
        input  stall, pc_write, ifid_write, flush_ifid,
               fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_regwrite, id_memread, id_dest, branch_taken,
        output stall, pc_write, ifid_write, flush_ifid,
               fwd_a_sel, fwd_b_sel, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Per-source youngest-match against the scoreboard and select/stall encoding.
// HAZARD_FORWARD_EN defined: forward from any stage, stall only on load-use; undefined: stall until write-back.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int REG_BITS   = 5,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  sb_entry_t [DEPTH:1] i_sb,
    input  logic [REG_BITS-1:0] i_src,
    input  logic                i_used,
    output logic                o_stall_req,
    output logic [SEL_W-1:0]    o_sel
);

    logic             w_hit;
    logic [SEL_W-1:0] w_stage;
    logic             w_load;
    logic             w_load_use;

    always_comb begin
        w_hit   = 1'b0;
        w_stage = '0;
        w_load  = 1'b0;
        // Scan oldest to youngest so the youngest match is the one that sticks.
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_sb[k].valid && (i_sb[k].dest == SB_DEST_W'(i_src))) begin
                w_hit   = 1'b1;
                w_stage = SEL_W'(stage_sel(k));
                w_load  = i_sb[k].is_load;
            end
        end
        if (!i_used || (i_src == '0)) begin
            w_hit   = 1'b0;
            w_stage = '0;
            w_load  = 1'b0;
        end
    end

    assign w_load_use = w_hit && w_load && (w_stage < SEL_W'(LOAD_STAGE));

`ifdef HAZARD_FORWARD_EN
    assign o_stall_req = w_load_use;
    assign o_sel       = (w_hit && !w_load_use) ? w_stage : SEL_W'(FWD_RF);
`else
    // Load-use is a subset of "not yet in the register file" since LOAD_STAGE <= DEPTH.
    assign o_stall_req = w_hit && ((w_stage < SEL_W'(DEPTH)) || w_load_use);
    assign o_sel       = SEL_W'(FWD_RF);
`endif

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control beside decode: scoreboard, load-use stall, branch flush.
// Forwarding behaviour selected by HAZARD_FORWARD_EN (see hazard_match).
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_BITS     = 5,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int LOAD_STAGE   = LOAD_STAGE_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int SEL_W        = $clog2(DEPTH + 1)
) (
    input  logic         Clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    sb_entry_t [DEPTH:1] r_sb;
    logic [FC_W-1:0]     r_flush_cnt;
    logic [31:0]         r_stall_cnt;

    logic             w_stall_a;
    logic             w_stall_b;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_stall;
    logic             w_br_accept;
    logic             w_flush;

    hazard_match #(
        .REG_BITS  (REG_BITS),
        .DEPTH     (DEPTH),
        .LOAD_STAGE(LOAD_STAGE),
        .SEL_W     (SEL_W)
    ) u_match_rs (
        .i_sb       (r_sb),
        .i_src      (hz.id_rs),
        .i_used     (hz.id_uses_rs),
        .o_stall_req(w_stall_a),
        .o_sel      (w_sel_a)
    );

    hazard_match #(
        .REG_BITS  (REG_BITS),
        .DEPTH     (DEPTH),
        .LOAD_STAGE(LOAD_STAGE),
        .SEL_W     (SEL_W)
    ) u_match_rt (
        .i_sb       (r_sb),
        .i_src      (hz.id_rt),
        .i_used     (hz.id_uses_rt),
        .o_stall_req(w_stall_b),
        .o_sel      (w_sel_b)
    );

    assign w_stall     = hz.id_valid && (w_stall_a || w_stall_b);
    // A branch seen while stalled is dropped; decode presents it again once the stall clears.
    assign w_br_accept = hz.branch_taken && !w_stall;
    assign w_flush     = w_br_accept || (r_flush_cnt != '0);

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_sb        <= '0;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_sb[1] <= '{valid:   hz.id_valid && hz.id_regwrite && (hz.id_dest != '0)
                                  && !w_stall && !w_flush,
                         dest:    SB_DEST_W'(hz.id_dest),
                         is_load: hz.id_memread};
            for (int k = 2; k <= DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end

            if (w_br_accept) begin
                r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end

            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign hz.stall      = w_stall;
    assign hz.pc_write   = ~w_stall;
    assign hz.ifid_write = ~w_stall;
    assign hz.flush_ifid = w_flush;
    assign hz.fwd_a_sel  = w_sel_a;
    assign hz.fwd_b_sel  = w_sel_b;
    assign hz.stall_cnt  = r_stall_cnt;

endmodule
